fifo_axis_packer: RTL

Downstream consumer of the team's synchronous FIFO. Pops narrow words from the FIFO's first-word-fall-through head and packs RATIO words into one wide AXI-Stream beat with per-lane keep and packet framing (last). Sits between the FIFO and the stream sink. Optionally flushes a partial beat after an idle timeout.

---
 rtl/fifo_axis_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_axis_packer.sv
// fifo_axis_packer: pops narrow words from a first-word-fall-through FIFO head
// and packs RATIO of them into one wide AXI-Stream beat with per-lane keep and
// packet framing (m_last_o every PKT_BEATS beats).
//
// Optional feature: define FIFO_AXIS_PACKER_TIMEOUT_EN to flush a partially
// filled beat (partial keep, last=1) after TIMEOUT consecutive idle cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | popping FIFO words into lanes of data_r; no beat offered
// HOLD  | full (or flushed) beat offered on m_*; waiting for m_ready_i
module fifo_axis_packer #(
  parameter int T_DATA_WIDTH = 8,
  parameter int RATIO        = 4,
  parameter int PKT_BEATS    = 16,
  parameter int TIMEOUT      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [T_DATA_WIDTH-1:0]       fifo_data_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_pop_o,
  output logic [RATIO*T_DATA_WIDTH-1:0] m_data_o,
  output logic [RATIO-1:0]              m_keep_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i
);

  localparam int LANE_W = $clog2(RATIO);
  localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_BEATS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                        state;
  logic [LANE_W-1:0]             lane_cnt;
  logic [BEAT_W-1:0]             beat_cnt;
  logic [RATIO*T_DATA_WIDTH-1:0] data_r;
  logic [RATIO-1:0]              keep_r;
  logic                          last_r;
  logic                          pop;

  // Pop only while filling and the FIFO has a word; m_ready_i is deliberately
  // kept out of this path.
  assign pop        = (state == FILL) && !fifo_empty_i;
  assign fifo_pop_o = pop;

  assign m_valid_o = (state == HOLD);
  assign m_data_o  = data_r;
  assign m_keep_o  = keep_r;
  assign m_last_o  = last_r;

`ifdef FIFO_AXIS_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  // Flush fires on the TIMEOUT-th idle cycle, so compare against TIMEOUT-1
  // before the increment that would reach TIMEOUT.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              flush;

  assign flush = (state == FILL) && (lane_cnt != '0) && !pop &&
                 (idle_cnt == IDLE_LAST);
`endif

  // Packing FSM: lane fill, beat hand-off and packet position tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      lane_cnt <= '0;
      beat_cnt <= '0;
      data_r   <= '0;
      keep_r   <= '0;
      last_r   <= 1'b0;
`ifdef FIFO_AXIS_PACKER_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            data_r[lane_cnt*T_DATA_WIDTH +: T_DATA_WIDTH] <= fifo_data_i;
            keep_r[lane_cnt] <= 1'b1;
            if (lane_cnt == LANE_MAX) begin
              lane_cnt <= '0;
              last_r   <= (beat_cnt == BEAT_MAX);
              state    <= HOLD;
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
`ifdef FIFO_AXIS_PACKER_TIMEOUT_EN
          if (pop) begin
            idle_cnt <= '0;
          end else if (flush) begin
            // Partial beat closes the packet; acceptance then restarts beat_cnt.
            idle_cnt <= '0;
            lane_cnt <= '0;
            last_r   <= 1'b1;
            state    <= HOLD;
          end else if (lane_cnt != '0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (m_ready_i) begin
            beat_cnt <= last_r ? '0 : beat_cnt + 1'b1;
            data_r   <= '0;
            keep_r   <= '0;
            last_r   <= 1'b0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
